pal_video_timing: RTL and testbench

Generates 15 kHz PAL raster timing for the video path and merges the pixel generator's colour with border and blanking. It sits directly upstream of the VGA scandoubler: its `ro/go/bo`, `hsync_ext_n` and `vsync_ext_n` outputs drive the scandoubler's `ri/gi/bi`, `hsync_ext_n` and `vsync_ext_n` inputs. It also supplies raster counters to the pixel generator and frame/line interrupt requests to the CPU.

---
 rtl/pal_video_timing.sv | 212 +++++++++++++++++++++
 tb/tb_pal_video_timing.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_video_timing.sv
// pal_video_timing
// 15 kHz PAL raster generator. Produces the horizontal/vertical counters for
// the pixel generator, merges pixel colour with border and blanking, and
// drives active-low syncs plus frame/line interrupt pulses. Everything runs
// on clkvideo with a synchronous active-high reset.
//
// Build option: define PAL_VIDEO_TIMING_LINE_INT_EN to build the line
// interrupt comparator and its pulse counter. Without it line_int_n is tied
// high and lineint_value is ignored.
module pal_video_timing #(
    parameter int HTOTAL       = 768,
    parameter int HACTIVE      = 512,
    parameter int HBLANK_START = 640,
    parameter int HBLANK_END   = 704,
    parameter int HSYNC_START  = 656,
    parameter int HSYNC_LEN    = 56,
    parameter int VTOTAL       = 312,
    parameter int VACTIVE      = 192,
    parameter int VBLANK_START = 240,
    parameter int VBLANK_END   = 264,
    parameter int VSYNC_START  = 244,
    parameter int VSYNC_LEN    = 4,
    parameter int INT_LEN      = 384
) (
    input  logic       clkvideo,
    input  logic       rst,
    input  logic [2:0] ri,
    input  logic [2:0] gi,
    input  logic [2:0] bi,
    input  logic [8:0] border,
    input  logic [7:0] lineint_value,
    output logic [9:0] hc,
    output logic [8:0] vc,
    output logic       display,
    output logic [2:0] ro,
    output logic [2:0] go,
    output logic [2:0] bo,
    output logic       hsync_ext_n,
    output logic       vsync_ext_n,
    output logic       frame_int_n,
    output logic       line_int_n
);

    // Colour triple, laid out to match the packed {r,g,b} border input.
    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb_t;

    // Screen region of the current raster position.
    typedef enum logic [1:0] {
        REGION_ACTIVE,
        REGION_BORDER,
        REGION_BLANK
    } region_t;

    // Counter-width copies of the timing parameters so every compare is
    // between equally sized operands.
    localparam logic [9:0] H_LAST        = 10'(HTOTAL - 1);
    localparam logic [9:0] H_ACTIVE      = 10'(HACTIVE);
    localparam logic [9:0] H_BLANK_START = 10'(HBLANK_START);
    localparam logic [9:0] H_BLANK_END   = 10'(HBLANK_END);
    localparam logic [9:0] H_SYNC_START  = 10'(HSYNC_START);
    localparam logic [9:0] H_SYNC_END    = 10'(HSYNC_START + HSYNC_LEN);
    localparam logic [8:0] V_LAST        = 9'(VTOTAL - 1);
    localparam logic [8:0] V_ACTIVE      = 9'(VACTIVE);
    localparam logic [8:0] V_BLANK_START = 9'(VBLANK_START);
    localparam logic [8:0] V_BLANK_END   = 9'(VBLANK_END);
    localparam logic [8:0] V_SYNC_START  = 9'(VSYNC_START);
    localparam logic [8:0] V_SYNC_END    = 9'(VSYNC_START + VSYNC_LEN);
    localparam logic [9:0] INT_LOAD      = 10'(INT_LEN);

    logic       h_last;
    logic       v_last;
    logic       h_blank;
    logic       v_blank;
    logic       hsync_on;
    logic       vsync_on;
    logic       frame_trig;
    region_t    region;
    rgb_t       pixel_rgb;
    rgb_t       border_rgb;
    rgb_t       rgb_next;
    logic [9:0] frame_cnt;
    logic [9:0] frame_cnt_next;

    // Interrupt pulse counter step: a trigger (re)loads the full width,
    // otherwise count down and rest at zero.
    function automatic logic [9:0] pulse_next(input logic       trig,
                                              input logic [9:0] cnt);
        if (trig) begin
            return INT_LOAD;
        end else if (cnt != 10'd0) begin
            return cnt - 10'd1;
        end else begin
            return 10'd0;
        end
    endfunction

    // Position decode on the current (zero-latency) counters.
    assign h_last     = (hc == H_LAST);
    assign v_last     = (vc == V_LAST);
    assign display    = (hc < H_ACTIVE) && (vc < V_ACTIVE);
    assign h_blank    = (hc >= H_BLANK_START) && (hc < H_BLANK_END);
    assign v_blank    = (vc >= V_BLANK_START) && (vc < V_BLANK_END);
    assign hsync_on   = (hc >= H_SYNC_START) && (hc < H_SYNC_END);
    assign vsync_on   = (vc >= V_SYNC_START) && (vc < V_SYNC_END);
    assign frame_trig = (vc == V_SYNC_START) && (hc == 10'd0);

    assign pixel_rgb  = '{r: ri, g: gi, b: bi};
    assign border_rgb = rgb_t'(border);

    // Raster counters: hc every cycle, vc on each hc wrap.
    always_ff @(posedge clkvideo) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            hc <= 10'd0;
            vc <= 9'd0;
        end else if (h_last) begin
            hc <= 10'd0;
            vc <= v_last ? 9'd0 : vc + 9'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    // Classify the current position; blanking overrides active and border.
    always_comb begin
        // NOTE: assigning a default before any branch keeps this block purely
        // combinational; a missed path would otherwise infer a latch.
        region = REGION_BORDER;
        if (h_blank || v_blank) begin
            region = REGION_BLANK;
        end else if (display) begin
            region = REGION_ACTIVE;
        end
    end

    // Colour selected by region, registered below.
    always_comb begin
        rgb_next = '0;
        case (region)
            REGION_ACTIVE: rgb_next = pixel_rgb;
            REGION_BORDER: rgb_next = border_rgb;
            default:       rgb_next = '0;
        endcase
    end

    // Next value of the frame interrupt pulse counter.
    always_comb begin
        frame_cnt_next = pulse_next(frame_trig, frame_cnt);
    end

    // Registered colour, syncs and frame interrupt: one cycle behind hc/vc.
    always_ff @(posedge clkvideo) begin
        if (rst) begin
            ro          <= 3'd0;
            go          <= 3'd0;
            bo          <= 3'd0;
            hsync_ext_n <= 1'b1;
            vsync_ext_n <= 1'b1;
            frame_cnt   <= 10'd0;
            frame_int_n <= 1'b1;
        end else begin
            ro          <= rgb_next.r;
            go          <= rgb_next.g;
            bo          <= rgb_next.b;
            hsync_ext_n <= ~hsync_on;
            // vc only moves on an hc wrap, so vsync is line aligned.
            vsync_ext_n <= ~vsync_on;
            frame_cnt   <= frame_cnt_next;
            frame_int_n <= (frame_cnt_next == 10'd0);
        end
    end

`ifdef PAL_VIDEO_TIMING_LINE_INT_EN
    logic [8:0] line_target;
    logic       line_valid;
    logic       line_trig;
    logic [9:0] line_cnt;
    logic [9:0] line_cnt_next;

    // Line numbers at or beyond the active area never fire (e.g. 0xFF).
    assign line_target = {1'b0, lineint_value};
    assign line_valid  = (line_target < V_ACTIVE);
    assign line_trig   = line_valid && (hc == H_ACTIVE) && (vc == line_target);

    // Next value of the line interrupt pulse counter.
    always_comb begin
        line_cnt_next = pulse_next(line_trig, line_cnt);
    end

    // Line interrupt pulse, independent of the frame interrupt.
    always_ff @(posedge clkvideo) begin
        if (rst) begin
            line_cnt   <= 10'd0;
            line_int_n <= 1'b1;
        end else begin
            line_cnt   <= line_cnt_next;
            line_int_n <= (line_cnt_next == 10'd0);
        end
    end
`else
    // Line interrupt not built: input is deliberately left unused.
    logic lineint_unused;
    assign lineint_unused = ^lineint_value;
    assign line_int_n     = 1'b1;
`endif

endmodule

// File: tb/tb_pal_video_timing.sv
// tb_pal_video_timing
// Directed bench. One instance uses the default PAL parameters for
// line-level checks (reset, hsync, colour path); a second instance uses a
// reduced raster so whole frames (vsync, interrupts, mid-frame reset) stay
// short. Outputs are sampled 1 time unit after each rising edge.
module tb_pal_video_timing;

    // Reduced raster for frame-level scenarios.
    localparam int S_HTOTAL       = 96;
    localparam int S_HACTIVE      = 64;
    localparam int S_HBLANK_START = 80;
    localparam int S_HBLANK_END   = 88;
    localparam int S_HSYNC_START  = 82;
    localparam int S_HSYNC_LEN    = 4;
    localparam int S_VTOTAL       = 40;
    localparam int S_VACTIVE      = 24;
    localparam int S_VBLANK_START = 30;
    localparam int S_VBLANK_END   = 34;
    localparam int S_VSYNC_START  = 31;
    localparam int S_VSYNC_LEN    = 2;
    localparam int S_INT_LEN      = 48;
    localparam int S_FRAME        = S_HTOTAL * S_VTOTAL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Default-parameter instance
    logic [2:0] ri_d = '0, gi_d = '0, bi_d = '0;
    logic [8:0] border_d = 9'o725;
    logic [7:0] lineint_d = 8'hFF;
    logic [9:0] hc_d;
    logic [8:0] vc_d;
    logic       display_d;
    logic [2:0] ro_d, go_d, bo_d;
    logic       hsync_d, vsync_d, frame_d, line_d;

    // Reduced-parameter instance
    logic [2:0] ri_s = '0, gi_s = '0, bi_s = '0;
    logic [8:0] border_s = 9'o725;
    logic [7:0] lineint_s = 8'hFF;
    logic [9:0] hc_s;
    logic [8:0] vc_s;
    logic       display_s;
    logic [2:0] ro_s, go_s, bo_s;
    logic       hsync_s, vsync_s, frame_s, line_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pal_video_timing dut (
        .clkvideo(clk), .rst(rst),
        .ri(ri_d), .gi(gi_d), .bi(bi_d),
        .border(border_d), .lineint_value(lineint_d),
        .hc(hc_d), .vc(vc_d), .display(display_d),
        .ro(ro_d), .go(go_d), .bo(bo_d),
        .hsync_ext_n(hsync_d), .vsync_ext_n(vsync_d),
        .frame_int_n(frame_d), .line_int_n(line_d)
    );

    pal_video_timing #(
        .HTOTAL(S_HTOTAL), .HACTIVE(S_HACTIVE),
        .HBLANK_START(S_HBLANK_START), .HBLANK_END(S_HBLANK_END),
        .HSYNC_START(S_HSYNC_START), .HSYNC_LEN(S_HSYNC_LEN),
        .VTOTAL(S_VTOTAL), .VACTIVE(S_VACTIVE),
        .VBLANK_START(S_VBLANK_START), .VBLANK_END(S_VBLANK_END),
        .VSYNC_START(S_VSYNC_START), .VSYNC_LEN(S_VSYNC_LEN),
        .INT_LEN(S_INT_LEN)
    ) dut_s (
        .clkvideo(clk), .rst(rst),
        .ri(ri_s), .gi(gi_s), .bi(bi_s),
        .border(border_s), .lineint_value(lineint_s),
        .hc(hc_s), .vc(vc_s), .display(display_s),
        .ro(ro_s), .go(go_s), .bo(bo_s),
        .hsync_ext_n(hsync_s), .vsync_ext_n(vsync_s),
        .frame_int_n(frame_s), .line_int_n(line_s)
    );

    // One clock; then act as pixel generator: colour = hc[2:0] on all guns.
    task automatic tick();
        logic [9:0] h;
        @(posedge clk);
        #1;
        h = hc_d;
        ri_d = h[2:0]; gi_d = h[2:0]; bi_d = h[2:0];
        h = hc_s;
        ri_s = h[2:0]; gi_s = h[2:0]; bi_s = h[2:0];
    endtask

    // Two reset edges; leaves both instances at (0,0) with rst released.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Run frames on the reduced instance, counting line interrupt low cycles.
    task automatic run_line(input int cycles, output int lows, output int first);
        lows = 0;
        first = -1;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (line_s !== 1'b1) begin
                lows++;
                if (first < 0) first = int'(vc_s) * 1000 + int'(hc_s);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({hc_d, vc_d} !== 19'd0) begin
            failures++;
            $display("FAIL reset_counters got hc=%0d vc=%0d exp 0 0", hc_d, vc_d);
        end
        checks++;
        if ({ro_d, go_d, bo_d} !== 9'o000) begin
            failures++;
            $display("FAIL reset_colour got %o exp 000", {ro_d, go_d, bo_d});
        end
        checks++;
        if ({hsync_d, vsync_d, frame_d, line_d} !== 4'b1111) begin
            failures++;
            $display("FAIL reset_flags got %b exp 1111", {hsync_d, vsync_d, frame_d, line_d});
        end
        checks++;
        if ({hc_s, vc_s, ro_s, go_s, bo_s} !== 28'd0 ||
            {hsync_s, vsync_s, frame_s, line_s} !== 4'b1111) begin
            failures++;
            $display("FAIL reset_small got hc=%0d vc=%0d flags=%b exp 0 0 1111",
                     hc_s, vc_s, {hsync_s, vsync_s, frame_s, line_s});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (hc_d !== 10'd1 || vc_d !== 9'd0 || hc_s !== 10'd1) begin
            failures++;
            $display("FAIL release_count got hc=%0d vc=%0d hc_s=%0d exp 1 0 1", hc_d, vc_d, hc_s);
        end
        checks++;
        if (display_d !== 1'b1) begin
            failures++;
            $display("FAIL display_origin got %b exp 1", display_d);
        end
        repeat (767) tick();
        checks++;
        if (hc_d !== 10'd0 || vc_d !== 9'd1) begin
            failures++;
            $display("FAIL line_wrap got hc=%0d vc=%0d exp 0 1", hc_d, vc_d);
        end
        checks++;
        if (hc_s !== 10'd0 || vc_s !== 9'd8) begin
            failures++;
            $display("FAIL small_wrap got hc=%0d vc=%0d exp 0 8", hc_s, vc_s);
        end
    endtask

    task automatic test_hsync();
        int lows = 0;
        int first = -1;
        int vlows = 0;
        do_reset();
        for (int i = 0; i < 768; i++) begin
            tick();
            if (hsync_d !== 1'b1) begin
                lows++;
                if (first < 0) first = int'(hc_d);
            end
            if (vsync_d !== 1'b1) vlows++;
        end
        checks++;
        if (lows != 56) begin
            failures++;
            $display("FAIL hsync_width got %0d exp 56", lows);
        end
        checks++;
        if (first != 657) begin
            failures++;
            $display("FAIL hsync_first got hc=%0d exp 657", first);
        end
        checks++;
        if (vlows != 0) begin
            failures++;
            $display("FAIL vsync_line0 got %0d low cycles exp 0", vlows);
        end
    endtask

    task automatic test_colour();
        logic [8:0] exp;
        logic       use_it;
        int         hits = 0;
        do_reset();
        for (int i = 0; i < 710; i++) begin
            tick();
            use_it = 1'b1;
            exp = 9'o000;
            // Sample at hc=N shows the colour for hc=N-1 on line 0.
            case (hc_d)
                10'd6:   exp = 9'o555;  // active, ri=5
                10'd512: exp = 9'o777;  // last active pixel 511
                10'd513: exp = 9'o725;  // first border pixel 512
                10'd601: exp = 9'o725;  // border at 600
                10'd640: exp = 9'o725;  // last border before blank (639)
                10'd641: exp = 9'o000;  // first blank column 640
                10'd651: exp = 9'o000;  // blank at 650
                10'd705: exp = 9'o725;  // left border from 704
                default: use_it = 1'b0;
            endcase
            if (use_it) begin
                hits++;
                checks++;
                if ({ro_d, go_d, bo_d} !== exp) begin
                    failures++;
                    $display("FAIL colour_hc%0d got %o exp %o", int'(hc_d) - 1, {ro_d, go_d, bo_d}, exp);
                end
            end
        end
        checks++;
        if (hits != 8) begin
            failures++;
            $display("FAIL colour_reach got %0d points exp 8", hits);
        end
    endtask

    task automatic test_frame();
        int vlows = 0, vfirst = -1, flows = 0, ffirst = -1, falls = 0, hits = 0;
        int vlast = -1;
        logic prev_h = 1'b1;
        logic [8:0] exp;
        logic use_it;
        do_reset();
        for (int i = 0; i < S_FRAME; i++) begin
            tick();
            if (vsync_s !== 1'b1) begin
                vlows++;
                if (vfirst < 0) vfirst = int'(vc_s) * 1000 + int'(hc_s);
                vlast = int'(vc_s) * 1000 + int'(hc_s);
            end
            if (frame_s !== 1'b1) begin
                flows++;
                if (ffirst < 0) ffirst = int'(vc_s) * 1000 + int'(hc_s);
            end
            if (prev_h === 1'b1 && hsync_s === 1'b0) falls++;
            prev_h = hsync_s;
            use_it = (hc_s == 10'd6) || (hc_s == 10'd71);
            exp = 9'o725;
            case ({vc_s, hc_s})
                {9'd23, 10'd6}:  exp = 9'o555;  // last active line
                {9'd24, 10'd6}:  exp = 9'o725;  // first border line
                {9'd29, 10'd71}: exp = 9'o725;  // border corner
                {9'd32, 10'd6}:  exp = 9'o000;  // vblank
                {9'd34, 10'd6}:  exp = 9'o725;  // first line after vblank
                default: use_it = 1'b0;
            endcase
            if (use_it) begin
                hits++;
                checks++;
                if ({ro_s, go_s, bo_s} !== exp) begin
                    failures++;
                    $display("FAIL colour_v%0d got %o exp %o", vc_s, {ro_s, go_s, bo_s}, exp);
                end
            end
        end
        checks++;
        if (vlows != S_VSYNC_LEN * S_HTOTAL) begin
            failures++;
            $display("FAIL vsync_width got %0d exp %0d", vlows, S_VSYNC_LEN * S_HTOTAL);
        end
        checks++;
        if (vfirst != 31001 || vlast != 33000) begin
            failures++;
            $display("FAIL vsync_edges got first=%0d last=%0d exp 31001 33000", vfirst, vlast);
        end
        checks++;
        if (flows != S_INT_LEN || ffirst != 31001) begin
            failures++;
            $display("FAIL frame_int got %0d at %0d exp %0d at 31001", flows, ffirst, S_INT_LEN);
        end
        checks++;
        if (falls != S_VTOTAL) begin
            failures++;
            $display("FAIL hsync_per_frame got %0d exp %0d", falls, S_VTOTAL);
        end
        checks++;
        if (hits != 5) begin
            failures++;
            $display("FAIL frame_colour_reach got %0d exp 5", hits);
        end
    endtask

    task automatic test_line_int();
        int lows, first;
        do_reset();
        lineint_s = 8'd10;
        run_line(S_FRAME, lows, first);
`ifdef PAL_VIDEO_TIMING_LINE_INT_EN
        checks++;
        if (lows != S_INT_LEN || first != 10065) begin
            failures++;
            $display("FAIL line_int_10 got %0d at %0d exp %0d at 10065", lows, first, S_INT_LEN);
        end
        lineint_s = 8'd23;
        run_line(S_FRAME, lows, first);
        checks++;
        if (lows != S_INT_LEN || first != 23065) begin
            failures++;
            $display("FAIL line_int_23 got %0d at %0d exp %0d at 23065", lows, first, S_INT_LEN);
        end
        lineint_s = 8'd24;
        run_line(S_FRAME, lows, first);
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL line_int_vactive got %0d low exp 0", lows);
        end
`else
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL line_int_tied got %0d low exp 0", lows);
        end
`endif
        lineint_s = 8'hFF;
        run_line(2 * S_FRAME, lows, first);
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL line_int_ff got %0d low exp 0", lows);
        end
    endtask

    task automatic test_mid_reset();
        int flows = 0;
        do_reset();
        repeat (S_VSYNC_START * S_HTOTAL + 20) tick();
        checks++;
        if (hc_s !== 10'd20 || vc_s !== 9'd31 || vsync_s !== 1'b0 || frame_s !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset got hc=%0d vc=%0d vs=%b fi=%b exp 20 31 0 0",
                     hc_s, vc_s, vsync_s, frame_s);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({hc_s, vc_s} !== 19'd0 || {vsync_s, frame_s, hsync_s} !== 3'b111 ||
            {ro_s, go_s, bo_s} !== 9'o000) begin
            failures++;
            $display("FAIL mid_reset got hc=%0d vc=%0d flags=%b exp 0 0 111",
                     hc_s, vc_s, {vsync_s, frame_s, hsync_s});
        end
        tick();
        checks++;
        if (hc_s !== 10'd1 || vc_s !== 9'd0) begin
            failures++;
            $display("FAIL resume got hc=%0d vc=%0d exp 1 0", hc_s, vc_s);
        end
        repeat (S_VSYNC_START * S_HTOTAL - 1) begin
            tick();
            if (frame_s !== 1'b1) flows++;
        end
        checks++;
        if (flows != 0) begin
            failures++;
            $display("FAIL pulse_cancel got %0d low exp 0", flows);
        end
        tick();
        checks++;
        if (hc_s !== 10'd1 || vc_s !== 9'd31 || frame_s !== 1'b0 || vsync_s !== 1'b0) begin
            failures++;
            $display("FAIL resume_frame got hc=%0d vc=%0d fi=%b vs=%b exp 1 31 0 0",
                     hc_s, vc_s, frame_s, vsync_s);
        end
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_colour();
        test_frame();
        test_line_int();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
